// File: rtl/demux1x8_deser.sv
// Serial-to-parallel receiver: assembles NBITS strobed bits into a word behind a valid/ready output register.
// Optional even-parity trailer bit per frame when PARITY_EN is defined.
module demux1x8_deser #(
  parameter int unsigned NBITS     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned CW       = (NBITS > 1) ? $clog2(NBITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_i,
  input  logic             sin_valid_i,
  input  logic             sof_i,
  output logic [CW-1:0]    sel_o,
  output logic             busy_o,
  output logic [NBITS-1:0] dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic             overrun_o,
  output logic             framing_err_o,
  output logic             parity_err_o
);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_e;
`endif

  localparam logic [CW-1:0] LAST_SEL = CW'(NBITS - 1);
  localparam logic [CW-1:0] IDX0     = LSB_FIRST ? CW'(0) : CW'(NBITS - 1);

  state_e           state_q;
  logic [CW-1:0]    sel_q;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] dout_q;
  logic             dout_valid_q;
  logic             overrun_q;
  logic             framing_err_q;

  logic [CW-1:0]    idx_c;
  logic [NBITS-1:0] word_c;
  logic [NBITS-1:0] first_c;
  logic [NBITS-1:0] deliver_word_c;
  logic             last_c;
  logic             deliver_c;

`ifdef PARITY_EN
  logic parity_err_q;
  logic par_ok_c;
`endif

  // Bit placement, current-word merge and completion detection
  always_comb begin
    idx_c          = LSB_FIRST ? sel_q : (LAST_SEL - sel_q);
    word_c         = shift_q;
    word_c[idx_c]  = sin_i;
    first_c        = '0;
    first_c[IDX0]  = sin_i;
    last_c         = (sel_q == LAST_SEL);
    deliver_c      = 1'b0;
    deliver_word_c = word_c;
`ifdef PARITY_EN
    par_ok_c       = ~(^shift_q ^ sin_i);
`endif
    if (sin_valid_i) begin
      case (state_q)
`ifdef PARITY_EN
        PAR: begin
          deliver_c      = par_ok_c;
          deliver_word_c = shift_q;
        end
`else
        SHIFT: deliver_c = !sof_i && last_c;
`endif
        default: deliver_c = 1'b0;
      endcase
    end
  end

  // Frame FSM, shifter and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      shift_q       <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
`ifdef PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
`ifdef PARITY_EN
      parity_err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (sin_valid_i && sof_i) begin
            shift_q <= first_c;
            sel_q   <= CW'(1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (sin_valid_i) begin
            if (sof_i) begin
              // Restart: partial word is discarded, not merged
              framing_err_q <= 1'b1;
              shift_q       <= first_c;
              sel_q         <= CW'(1);
            end else if (last_c) begin
              shift_q <= word_c;
              sel_q   <= '0;
`ifdef PARITY_EN
              state_q <= PAR;
`else
              state_q <= IDLE;
`endif
            end else begin
              shift_q <= word_c;
              sel_q   <= sel_q + CW'(1);
            end
          end
        end
`ifdef PARITY_EN
        PAR: begin
          if (sin_valid_i) begin
            parity_err_q <= !par_ok_c;
            state_q      <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase

      if (deliver_c) begin
        if (dout_valid_q && !dout_ready_i) begin
          overrun_q <= 1'b1;
        end else begin
          dout_q       <= deliver_word_c;
          dout_valid_q <= 1'b1;
        end
      end else if (dout_valid_q && dout_ready_i) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign sel_o         = sel_q;
  assign busy_o        = (state_q != IDLE);
  assign dout_o        = dout_q;
  assign dout_valid_o  = dout_valid_q;
  assign overrun_o     = overrun_q;
  assign framing_err_o = framing_err_q;
`ifdef PARITY_EN
  assign parity_err_o  = parity_err_q;
`else
  assign parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_demux1x8_deser.sv
// Directed bench for demux1x8_deser (NBITS=8, LSB_FIRST=1); parity steps only when PARITY_EN is defined.
module tb_demux1x8_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sof = 1'b0;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic       overrun;
  logic       framing_err;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  demux1x8_deser #(.NBITS(8), .LSB_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .sin_i        (sin),
    .sin_valid_i  (sin_valid),
    .sof_i        (sof),
    .sel_o        (sel),
    .busy_o       (busy),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .overrun_o    (overrun),
    .framing_err_o(framing_err),
    .parity_err_o (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input logic s);
    sin       = b;
    sin_valid = 1'b1;
    sof       = s;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sof       = 1'b0;
    sin       = 1'b0;
  endtask

  // sof + bits 0..6
  task automatic send_head(input logic [7:0] w);
    strobe(w[0], 1'b1);
    for (int k = 1; k < 7; k++) strobe(w[k], 1'b0);
  endtask

  // bit 7 (+ parity), ready applied for the completing strobe
  task automatic send_tail(input logic [7:0] w, input logic rdy_last);
`ifdef PARITY_EN
    strobe(w[7], 1'b0);
    dout_ready = rdy_last;
    strobe(^w, 1'b0);
`else
    dout_ready = rdy_last;
    strobe(w[7], 1'b0);
`endif
  endtask

  task automatic send_frame(input logic [7:0] w, input logic rdy_last);
    send_head(w);
    send_tail(w, rdy_last);
  endtask

  initial begin
    // reset state
    idle();
    idle();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_pulses", 32'({overrun, framing_err, parity_err}), 32'd0);
    rst = 1'b0;
    idle();

    // stray bit in IDLE is ignored
    strobe(1'b1, 1'b0);
    chk("idle_ign_busy", 32'(busy), 32'd0);
    chk("idle_ign_sel", 32'(sel), 32'd0);

    // 0xA5, LSB first, ready high
    dout_ready = 1'b1;
    send_head(8'hA5);
    chk("a5_sel7", 32'(sel), 32'd7);
    chk("a5_busy", 32'(busy), 32'd1);
    chk("a5_valid_early", 32'(dout_valid), 32'd0);
    idle();
    chk("a5_gap_hold_sel", 32'(sel), 32'd7);
    send_tail(8'hA5, 1'b1);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_valid", 32'(dout_valid), 32'd1);
    chk("a5_idle_after", 32'({busy, sel}), 32'd0);
    chk("a5_no_parerr", 32'(parity_err), 32'd0);
    idle();
    chk("a5_consumed", 32'(dout_valid), 32'd0);
    chk("a5_dout_hold", 32'(dout), 32'hA5);

    // back-to-back frames into a full output register
    dout_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    chk("3c_dout", 32'(dout), 32'h3C);
    chk("3c_no_ovr", 32'(overrun), 32'd0);
    send_frame(8'hC3, 1'b0);
    chk("c3_overrun", 32'(overrun), 32'd1);
    chk("c3_dout_kept", 32'(dout), 32'h3C);
    chk("c3_valid", 32'(dout_valid), 32'd1);
    idle();
    chk("ovr_pulse_end", 32'(overrun), 32'd0);

    // completion coincides with consumer accept
    send_frame(8'h5A, 1'b1);
    chk("5a_dout", 32'(dout), 32'h5A);
    chk("5a_valid", 32'(dout_valid), 32'd1);
    chk("5a_no_ovr", 32'(overrun), 32'd0);
    idle();
    chk("5a_consumed", 32'(dout_valid), 32'd0);

    // sof at sel=4 restarts the frame
    strobe(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) strobe(1'b1, 1'b0);
    chk("fe_sel4", 32'(sel), 32'd4);
    chk("fe_no_err_yet", 32'(framing_err), 32'd0);
    strobe(1'b1, 1'b1);
    chk("fe_pulse", 32'(framing_err), 32'd1);
    chk("fe_sel_restart", 32'(sel), 32'd1);
    for (int k = 1; k < 7; k++) strobe(k == 7, 1'b0);
    chk("fe_pulse_end", 32'(framing_err), 32'd0);
    send_tail(8'h81, 1'b1);
    chk("81_dout", 32'(dout), 32'h81);
    chk("81_valid", 32'(dout_valid), 32'd1);

    // async reset mid-frame with a word still held
    dout_ready = 1'b0;
    strobe(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) strobe(1'b1, 1'b0);
    chk("mid_sel5", 32'(sel), 32'd5);
    chk("mid_valid_held", 32'(dout_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_dout", 32'(dout), 32'h00);
    chk("arst_valid", 32'(dout_valid), 32'd0);
    idle();
    rst = 1'b0;
    dout_ready = 1'b1;
    send_frame(8'h12, 1'b1);
    chk("post_rst_dout", 32'(dout), 32'h12);
    chk("post_rst_valid", 32'(dout_valid), 32'd1);
    idle();

`ifdef PARITY_EN
    // parity good then bad
    send_frame(8'h0F, 1'b1);
    chk("par_ok_dout", 32'(dout), 32'h0F);
    chk("par_ok_valid", 32'(dout_valid), 32'd1);
    chk("par_ok_noerr", 32'(parity_err), 32'd0);
    idle();
    chk("par_consumed", 32'(dout_valid), 32'd0);
    send_frame(8'hF0 ^ 8'hFF, 1'b1);
    idle();
    send_head(8'h33);
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    chk("par_bad_err", 32'(parity_err), 32'd1);
    chk("par_bad_valid", 32'(dout_valid), 32'd0);
    chk("par_bad_dout", 32'(dout), 32'h0F);
    idle();
    chk("par_err_end", 32'(parity_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
